// File: rtl/anim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : anim_pkg
// Purpose  : Shared state, mode and width definitions for the LED sweep block.
// Revision : 1.0 - initial release
// ============================================================================
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        NEXT = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CHASE    = 2'b00;
    localparam logic [1:0] MODE_PINGPONG = 2'b01;
    localparam logic [1:0] MODE_ALL      = 2'b10;

    // Width able to hold 0..max_duty inclusive.
    function automatic int dw_of(input int max_duty);
        return $clog2(max_duty + 1);
    endfunction

    // Width of an index/counter covering 0..n-1, never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_sweep_ctrl_if
// Purpose  : Animation-control and LED-side signal bundle of the sweep block.
// Revision : 1.0 - initial release
// ============================================================================
interface led_sweep_ctrl_if
    import anim_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int MAX_DUTY = 10
) ();

    localparam int DW = dw_of(MAX_DUTY);
    localparam int CW = cw_of(N_CH);

    logic            en;
    logic            start;
    logic [1:0]      mode;
    logic            loop;
    logic [N_CH-1:0] led;
    logic [DW-1:0]   duty;
    logic [CW-1:0]   ch_idx;
    logic            busy;
    logic            done;

    modport master (
        output en, start, mode, loop,
        input  led, duty, ch_idx, busy, done
    );

    modport slave (
        input  en, start, mode, loop,
        output led, duty, ch_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/breath_ramp.sv
`default_nettype none
// ============================================================================
// Module   : breath_ramp
// Purpose  : Step timer plus 0 -> MAX_DUTY -> 0 duty ramp for one channel visit.
// Revision : 1.0 - initial release
// ============================================================================
module breath_ramp
    import anim_pkg::*;
#(
    parameter int MAX_DUTY   = 10,
    parameter int STEP_TICKS = 20,
    parameter int DW         = dw_of(MAX_DUTY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go_i,
    input  logic          abort_i,
    output logic [DW-1:0] duty_o,
    output logic          peak_o,
    output logic          ramp_done_o
);

    localparam int SW = cw_of(STEP_TICKS);

    logic          active_q, active_d;
    logic          fall_q,   fall_d;
    logic [SW-1:0] step_q,   step_d;
    logic [DW-1:0] duty_q,   duty_d;
    logic          step_w;

    assign step_w      = active_q && (step_q == SW'(STEP_TICKS - 1));
    assign peak_o      = step_w && !fall_q && (duty_q == DW'(MAX_DUTY));
    assign ramp_done_o = step_w &&  fall_q && (duty_q == '0);
    assign duty_o      = duty_q;

    always_comb begin
        active_d = active_q;
        fall_d   = fall_q;
        step_d   = step_q;
        duty_d   = duty_q;
        if (abort_i) begin
            active_d = 1'b0;
            fall_d   = 1'b0;
            step_d   = '0;
            duty_d   = '0;
        end else if (go_i) begin
            active_d = 1'b1;
            fall_d   = 1'b0;
            step_d   = '0;
            duty_d   = '0;
        end else if (active_q) begin
            step_d = step_w ? '0 : step_q + SW'(1);
            if (step_w) begin
                if (!fall_q) begin
                    // Reaching the peak flips direction without touching duty.
                    if (duty_q == DW'(MAX_DUTY)) fall_d = 1'b1;
                    else                         duty_d = duty_q + DW'(1);
                end else begin
                    if (duty_q == '0) active_d = 1'b0;
                    else              duty_d   = duty_q - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            fall_q   <= 1'b0;
            step_q   <= '0;
            duty_q   <= '0;
        end else begin
            active_q <= active_d;
            fall_q   <= fall_d;
            step_q   <= step_d;
            duty_q   <= duty_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_sweep_ctrl
// Purpose  : Schedules the shared breathing ramp across LED channels; PWM out.
// Revision : 1.0 - initial release
// ============================================================================
module led_sweep_ctrl
    import anim_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int MAX_DUTY   = 10,
    parameter int STEP_TICKS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    led_sweep_ctrl_if.slave  bus
);

    localparam int DW = dw_of(MAX_DUTY);
    localparam int CW = cw_of(N_CH);
    localparam int PW = cw_of(MAX_DUTY);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
    localparam logic [CW-1:0] ONE_CH  = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q,    ch_d;
    logic            down_q,  down_d;
    logic [1:0]      mode_q,  mode_d;
    logic            loop_q,  loop_d;
    logic [PW-1:0]   pwm_q,   pwm_d;
    logic            done_q,  done_d;
    logic            busy_q;
    logic            go_w, peak_w, ramp_done_w, pass_end_w, turn_w;
    logic [DW-1:0]   duty_w;
    logic [N_CH-1:0] led_w;

    breath_ramp #(
        .MAX_DUTY   (MAX_DUTY),
        .STEP_TICKS (STEP_TICKS),
        .DW         (DW)
    ) u_ramp (
        .clk         (clk),
        .rst_n       (rst_n),
        .go_i        (go_w),
        .abort_i     (!bus.en),
        .duty_o      (duty_w),
        .peak_o      (peak_w),
        .ramp_done_o (ramp_done_w)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        down_d     = down_q;
        mode_d     = mode_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
        go_w       = 1'b0;
        pass_end_w = 1'b0;
        turn_w     = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            ch_d    = '0;
            down_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RISE;
                        mode_d  = bus.mode;
                        loop_d  = bus.loop;
                        ch_d    = '0;
                        down_d  = 1'b0;
                        go_w    = 1'b1;
                    end
                end
                RISE: if (peak_w)      state_d = FALL;
                FALL: if (ramp_done_w) state_d = NEXT;
                NEXT: begin
                    case (mode_q)
                        MODE_ALL: pass_end_w = 1'b1;
                        MODE_PINGPONG: begin
                            if (N_CH == 1) begin
                                pass_end_w = 1'b1;
                            end else begin
                                // Turning at the top channel counts as heading down already.
                                turn_w = down_q || (ch_q == LAST_CH);
                                if (turn_w && (ch_q == ONE_CH)) begin
                                    pass_end_w = 1'b1;
                                end else if (turn_w) begin
                                    down_d = 1'b1;
                                    ch_d   = ch_q - ONE_CH;
                                end else begin
                                    ch_d   = ch_q + ONE_CH;
                                end
                            end
                        end
                        default: begin
                            if (ch_q == LAST_CH) pass_end_w = 1'b1;
                            else                 ch_d       = ch_q + ONE_CH;
                        end
                    endcase
                    if (pass_end_w) begin
                        ch_d   = '0;
                        down_d = 1'b0;
                        if (loop_q) begin
                            state_d = RISE;
                            go_w    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = RISE;
                        go_w    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_d = pwm_q + PW'(1);
        if ((state_d == IDLE) || (state_q == IDLE) || (pwm_q == PW'(MAX_DUTY - 1))) begin
            pwm_d = '0;
        end
    end

    always_comb begin
        led_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            led_w[i] = busy_q && ((mode_q == MODE_ALL) || (ch_q == CW'(i)))
                       && (DW'(pwm_q) < duty_w);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            down_q  <= 1'b0;
            mode_q  <= MODE_CHASE;
            loop_q  <= 1'b0;
            pwm_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            down_q  <= down_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.led    = led_w;
    assign bus.duty   = duty_w;
    assign bus.ch_idx = ch_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sweep_ctrl
// Purpose  : Randomised self-checking bench for led_sweep_ctrl against a
//            cycle-indexed arithmetic model of the sweep schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_sweep_ctrl;
    import anim_pkg::*;

    localparam int N        = 8;
    localparam int MX       = 10;
    localparam int ST       = 20;
    localparam int RISE_LEN = (MX + 1) * ST;
    localparam int RAMP     = 2 * RISE_LEN + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    led_sweep_ctrl_if #(.N_CH(N), .MAX_DUTY(MX)) u_bus ();
    led_sweep_ctrl #(.N_CH(N), .MAX_DUTY(MX), .STEP_TICKS(ST)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    led_sweep_ctrl_if #(.N_CH(1), .MAX_DUTY(1)) u_bus_s ();
    led_sweep_ctrl #(.N_CH(1), .MAX_DUTY(1), .STEP_TICKS(1)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input int expv);
        n_tests++;
        if (got !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    function automatic int pass_len(input int n, input int md);
        if (md == 2) return 1;
        if (md == 1) return (n == 1) ? 1 : 2 * n - 2;
        return n;
    endfunction

    // k-th channel visited within one pass
    function automatic int chan_at(input int n, input int md, input int k);
        if (md == 2) return 0;
        if (md == 1 && k >= n) return 2 * n - 2 - k;
        return k;
    endfunction

    // Expected outputs t cycles after the start edge (t >= 1).
    task automatic model(input int n, input int mx, input int st, input int md,
                         input int lp, input int t, input int abort_at,
                         output int ed, output int ec, output int eb,
                         output int edn, output int el);
        int rise, ramp, len, o;
        ed = 0; ec = 0; eb = 0; edn = 0; el = 0;
        rise = (mx + 1) * st;
        ramp = 2 * rise + 1;
        len  = pass_len(n, md);
        if (abort_at > 0 && t > abort_at) return;
        if (lp == 0 && t > len * ramp) begin
            edn = (t == len * ramp + 1) ? 1 : 0;
            return;
        end
        eb = 1;
        o  = (t - 1) % ramp;
        ec = chan_at(n, md, ((t - 1) / ramp) % len);
        if (o < rise)          ed = o / st;
        else if (o < 2 * rise) ed = mx - (o - rise) / st;
        for (int i = 0; i < n; i++) begin
            if ((md == 2 || i == ec) && ((t - 1) % mx) < ed) el = el | (1 << i);
        end
    endtask

    task automatic check_main(input int md, input int lp, input int t, input int abort_at);
        int ed, ec, eb, edn, el;
        model(N, MX, ST, md, lp, t, abort_at, ed, ec, eb, edn, el);
        check($sformatf("duty@%0d", t),   32'(u_bus.duty),   ed);
        check($sformatf("ch_idx@%0d", t), 32'(u_bus.ch_idx), ec);
        check($sformatf("busy@%0d", t),   32'(u_bus.busy),   eb);
        check($sformatf("done@%0d", t),   32'(u_bus.done),   edn);
        check($sformatf("led@%0d", t),    32'(u_bus.led),    el);
    endtask

    // One start at cycle 0, then tend checked cycles; chaos adds ignored
    // start pulses and mode/loop churn while the sequence is running.
    task automatic run_scn(input int md, input int lp, input int abort_at,
                           input int tend, input bit chaos);
        int len;
        len = pass_len(N, md);
        @(negedge clk);
        u_bus.en    = 1'b1;
        u_bus.start = 1'b1;
        u_bus.mode  = 2'(md);
        u_bus.loop  = lp[0];
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            u_bus.start = 1'b0;
            check_main(md, lp, t, abort_at);
            u_bus.en = (t != abort_at);
            if (chaos) begin
                u_bus.mode = 2'($urandom_range(0, 3));
                u_bus.loop = 1'($urandom_range(0, 1));
                if ((lp != 0 || t <= len * RAMP) && (abort_at == 0 || t <= abort_at)
                    && $urandom_range(0, 15) == 0) begin
                    u_bus.start = 1'b1;
                end
            end
        end
        u_bus.en = 1'b1;
    endtask

    initial begin
        int md, lp, a, len, ed, ec, eb, edn, el;
        u_bus.en     = 1'b1;
        u_bus.start  = 1'b1;
        u_bus.mode   = 2'b00;
        u_bus.loop   = 1'b0;
        u_bus_s.en    = 1'b1;
        u_bus_s.start = 1'b0;
        u_bus_s.mode  = 2'b00;
        u_bus_s.loop  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(u_bus.busy),   0);
        check("rst_done", 32'(u_bus.done),   0);
        check("rst_duty", 32'(u_bus.duty),   0);
        check("rst_ch",   32'(u_bus.ch_idx), 0);
        check("rst_led",  32'(u_bus.led),    0);
        u_bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(u_bus.busy), 0);

        // start together with en low must not launch a sequence
        u_bus.start = 1'b1;
        u_bus.en    = 1'b0;
        @(negedge clk);
        u_bus.start = 1'b0;
        u_bus.en    = 1'b1;
        check("start_en_low_busy", 32'(u_bus.busy), 0);
        check("start_en_low_duty", 32'(u_bus.duty), 0);

        run_scn(0, 0, 0, N * RAMP + 4, 1'b0);
        run_scn(1, 0, 0, (2 * N - 2) * RAMP + 4, 1'b1);
        run_scn(2, 0, 0, RAMP + 4, 1'b1);
        a = 3 * RAMP + RISE_LEN + 1 + $urandom_range(0, RISE_LEN - 1);
        run_scn(0, 1, a, a + 4, 1'b1);

        for (int s = 0; s < 4; s++) begin
            md  = $urandom_range(0, 3);
            lp  = $urandom_range(0, 1);
            len = pass_len(N, md);
            if (lp != 0)                     a = $urandom_range(1, 2 * len * RAMP);
            else if ($urandom_range(0, 1)) a = $urandom_range(1, len * RAMP);
            else                             a = 0;
            run_scn(md, lp, a, (a > 0) ? a + 4 : len * RAMP + 4, 1'b1);
        end

        // Minimal configuration: one channel, peak 1, one tick per step.
        @(negedge clk);
        u_bus_s.start = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            u_bus_s.start = 1'b0;
            model(1, 1, 1, 0, 0, t, 0, ed, ec, eb, edn, el);
            check($sformatf("s_duty@%0d", t), 32'(u_bus_s.duty), ed);
            check($sformatf("s_busy@%0d", t), 32'(u_bus_s.busy), eb);
            check($sformatf("s_done@%0d", t), 32'(u_bus_s.done), edn);
            check($sformatf("s_led@%0d", t),  32'(u_bus_s.led),  el);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Sequencer that schedules the breathing duty ramp (0 → MAX_DUTY → 0) across a bank of LED channels and drives per-channel PWM outputs. It sits between top-level animation control (enable, mode, start) and the LED pins. It owns one shared ramp engine that visits channels in chase, ping-pong or all-together order, with single-pass or looping operation.

## Interface
- N_CH, 8, number of LED channels (≥1)
- MAX_DUTY, 10, peak duty level; also the PWM period in cycles (≥1)
- STEP_TICKS, 20, clock cycles per duty step (≥1)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global enable; low forces abort to IDLE
- start  in  1  single-cycle request to begin a sequence
- mode  in  2  00 chase, 01 ping-pong, 10 all, 11 reserved (treated as chase)
- loop  in  1  1 = repeat passes until en falls; 0 = single pass
- led  out  N_CH  PWM outputs
- duty  out  DW=$clog2(MAX_DUTY+1)  current ramp level
- ch_idx  out  $clog2(N_CH) (min 1)  active channel
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of a non-looping pass

## Operation
- Reset values: state IDLE, led 0, duty 0, ch_idx 0, busy 0, done 0, internal counters 0, direction up.
- IDLE: busy 0. start && en → RISE; latch mode and loop; duty 0, step_cnt 0, ch_idx 0, direction up. start while busy is ignored.
- step_cnt counts 0..STEP_TICKS-1 and wraps in RISE/FALL; a "step" is the wrap cycle.
- RISE: at a step, duty < MAX_DUTY → duty+1; duty == MAX_DUTY → FALL with duty unchanged.
- FALL: at a step, duty > 0 → duty-1; duty == 0 → NEXT.
- NEXT (one cycle): select the next channel, or end the pass.
  - Chase: ch_idx+1; pass ends when ch_idx == N_CH-1.
  - Ping-pong: up to N_CH-1, then down; pass ends in NEXT when direction down and ch_idx == 1 (N_CH == 1: after one ramp).
  - All: ch_idx stays 0; pass ends after one ramp.
  - Pass end with loop → ch_idx 0, direction up, RISE. Without loop → IDLE, done 1 for exactly that cycle.
- en low in any state: next cycle IDLE, duty 0, counters cleared, led 0. No done pulse.
- mode/loop changes while busy are ignored until the next start.
- PWM: pwm_cnt runs 0..MAX_DUTY-1 while busy and is held 0 in IDLE. led[i] = busy && (mode all || i == ch_idx) && pwm_cnt < duty. Duty 0 means off; duty MAX_DUTY means always on.

## Timing
- start sampled at edge k → busy and RISE from cycle k+1. duty is 0 during the first STEP_TICKS cycles.
- One channel ramp = (MAX_DUTY+1)·STEP_TICKS (RISE) + (MAX_DUTY+1)·STEP_TICKS (FALL) + 1 (NEXT). Defaults: 441 cycles.
- Default chase pass: busy cycles 1..3528; done=1 and busy=0 at cycle 3529.
- Ping-pong pass visits 2·N_CH-2 channels (14 with defaults; 1 if N_CH == 1). All mode = 1 ramp.
- led, duty, ch_idx are combinational from registered state; zero added latency. done and busy are registered.
- Simultaneous start and en low: en wins, stays IDLE. rst_n overrides everything.

## Structure
- Package anim_pkg: state enum (IDLE, RISE, FALL, NEXT), mode constants (MODE_CHASE, MODE_PINGPONG, MODE_ALL), width helper for DW.
- Sub-module breath_ramp: step counter plus RISE/FALL duty ramp, with ports go/abort/duty/ramp_done. led_sweep_ctrl handles channel scheduling, the PWM counter and the led decode.

## Test plan
- Reset then chase, loop 0, start at cycle 0 → ch_idx steps 0..7 every 441 cycles; done single pulse at cycle 3529; busy 0 after.
- Ping-pong, loop 0 → ch_idx sequence 0,1..7,6..1; done after 14·441 cycles; led only ever on the active channel.
- All mode, duty 5 → every led high for exactly 5 of each 10 cycles; duty 10 → all high continuously.
- Loop 1 chase, drop en mid-FALL on channel 3 → next cycle IDLE, led 0, duty 0, no done; a new start restarts at channel 0.
- Start pulsed while busy, and mode changed mid-run → sequence timing and order unchanged.
- N_CH=1, MAX_DUTY=1, STEP_TICKS=1 → ramp duty 0,1,1,0 then NEXT; done at cycle 6.
